// File: rtl/acq_trigger_ctrl_if.sv
// acq_trigger_ctrl_if: ADC sample stream into the sequencer and trace buffer write port out of it
interface acq_trigger_ctrl_if #(
    parameter int DW = 12,
    parameter int AW = 9
);
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    modport master (output sample_valid, sample, input wr_en, wr_addr, wr_data);
    modport slave (input sample_valid, sample, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/acq_trigger_ctrl.sv
// acq_trigger_ctrl: decimates ADC samples, arms an edge trigger and streams one screen into the trace buffer
module acq_trigger_ctrl #(
    parameter int DW       = 12,
    parameter int DEPTH    = 480,
    parameter int AW       = 9,
    parameter int AUTO_TMO = 2048
) (
    input  logic              clk,
    input  logic              reset,
    acq_trigger_ctrl_if.slave bus,
    input  logic [15:0]       decim,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_done,
    output logic              triggered,
    output logic              capture_done,
    output logic [1:0]        state_o
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3;
    localparam logic [1:0] M_AUTO = 2'd0, M_SINGLE = 2'd2;
    localparam int TW = $clog2(AUTO_TMO + 1);
    logic [15:0]   cnt, dec_q, lim;
    logic [DW-1:0] prev;
    logic          prev_vld, kept, edge_hit, fire, last;
    logic [TW-1:0] tmo;
    logic [AW-1:0] nxt_addr;
    // decim is taken live at the start of each count period, then held in dec_q
    always_comb begin
        lim      = (cnt == 16'd0) ? decim : dec_q;
        kept     = bus.sample_valid && cnt == lim;
        edge_hit = prev_vld && (trig_slope ? (prev > trig_level && bus.sample <= trig_level)
                                           : (prev < trig_level && bus.sample >= trig_level));
        fire     = kept && state_o == ARMED &&
                   (edge_hit || (mode == M_AUTO && tmo == TW'(AUTO_TMO - 1)));
        nxt_addr = (state_o == ARMED) ? '0 : bus.wr_addr + AW'(1);
        last     = nxt_addr == AW'(DEPTH - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_o      <= IDLE;
            cnt          <= '0;
            dec_q        <= '0;
            prev         <= '0;
            prev_vld     <= 1'b0;
            tmo          <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            if (bus.sample_valid) begin
                cnt <= kept ? 16'd0 : cnt + 16'd1;
                if (cnt == 16'd0) dec_q <= decim;
            end
            bus.wr_en    <= 1'b0;
            capture_done <= bus.wr_en && bus.wr_addr == AW'(DEPTH - 1);
            if (bus.wr_en && bus.wr_addr == AW'(DEPTH - 1)) triggered <= 1'b0;
            case (state_o)
                IDLE: if (arm || mode != M_SINGLE) begin
                    state_o  <= ARMED;
                    prev_vld <= 1'b0;
                    tmo      <= '0;
                end
                ARMED: if (kept) begin
                    prev     <= bus.sample;
                    prev_vld <= 1'b1;
                    tmo      <= fire ? '0 : tmo + TW'(1);
                end
                HOLD: if (frame_done) begin
                    state_o  <= (mode == M_SINGLE) ? IDLE : ARMED;
                    prev_vld <= 1'b0;
                    tmo      <= '0;
                end
                default: ;
            endcase
            // the trigger sample itself lands at address 0, later kept samples follow in order
            if (fire || (kept && state_o == CAPTURE)) begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= nxt_addr;
                bus.wr_data <= bus.sample;
                state_o     <= last ? HOLD : CAPTURE;
                if (fire) triggered <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// tb_acq_trigger_ctrl: scoreboard bench; expected writes are queued as samples are driven
module tb_acq_trigger_ctrl;
    localparam int DW = 12, AW = 9, DEPTH = 480;
    typedef struct {int addr; int data; int cyc;} exp_t;
    logic          clk = 1'b0, reset = 1'b1;
    logic [15:0]   decim = '0;
    logic [DW-1:0] trig_level = 12'd2048;
    logic          trig_slope = 1'b0;
    logic [1:0]    mode = 2'd1;
    logic          arm = 1'b0, frame_done = 1'b0;
    logic          triggered, capture_done;
    logic [1:0]    state_o;
    exp_t          q[$];
    int            tests = 0, fails = 0, ncyc = 0, wr_cnt = 0, cd_cnt = 0;
    logic          last_wr = 1'b0;

    acq_trigger_ctrl_if #(.DW(DW), .AW(AW)) bus();

    acq_trigger_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AUTO_TMO(2048)) dut (
        .clk(clk), .reset(reset), .bus(bus), .decim(decim), .trig_level(trig_level),
        .trig_slope(trig_slope), .mode(mode), .arm(arm), .frame_done(frame_done),
        .triggered(triggered), .capture_done(capture_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL write: unexpected write addr %0d data %0d at cycle %0d, required none",
                         bus.wr_addr, bus.wr_data, ncyc);
            end else begin
                e = q.pop_front();
                if (bus.wr_addr !== AW'(e.addr) || bus.wr_data !== DW'(e.data) || ncyc != e.cyc) begin
                    fails++;
                    $display("FAIL write: got addr %0d data %0d cycle %0d, required addr %0d data %0d cycle %0d",
                             bus.wr_addr, bus.wr_data, ncyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (capture_done === 1'b1) begin
            cd_cnt++;
            tests++;
            if (!last_wr) begin
                fails++;
                $display("FAIL capture_done_timing: pulse at cycle %0d, required only after write of addr %0d",
                         ncyc, DEPTH - 1);
            end
        end
        last_wr = bus.wr_en === 1'b1 && bus.wr_addr === AW'(DEPTH - 1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic v, input int s);
        bus.sample_valid = v;
        bus.sample = DW'(s);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic push(input int a, input int d);
        q.push_back('{a, d, ncyc + 2});
    endtask

    task automatic do_reset(input logic [1:0] m);
        mode = m;
        reset = 1'b1;
        repeat (2) tick(0, 0);
        reset = 1'b0;
        repeat (2) tick(0, 0);
    endtask

    function automatic int sine(input int k);
        return int'(2047.5 + 2047.0 * $sin(6.283185307179586 * real'(k) / 64.0));
    endfunction

    // reference model: starts from a fresh ARMED state; kind 0 ramp, 1 constant 1000, 2 sine
    task automatic stream(input int n, input int kind);
        int p = 0, pv = 0, tmo = 0, idx = -1, s;
        int lvl = int'(trig_level), d = int'(decim);
        for (int k = 0; k < n; k++) begin
            s = kind == 0 ? (16 * k) % 4096 : kind == 1 ? 1000 : sine(k);
            if (k % (d + 1) == d) begin
                if (idx < 0) begin
                    if (pv != 0 && (trig_slope ? (p > lvl && s <= lvl) : (p < lvl && s >= lvl))) idx = 0;
                    else if (mode == 2'd0 && tmo == 2047) idx = 0;
                    pv = 1;
                    p = s;
                    tmo++;
                end
                if (idx >= 0 && idx < DEPTH) begin
                    push(idx, s);
                    idx++;
                end
            end
            tick(1, s);
        end
        repeat (3) tick(0, 0);
    endtask

    task automatic test_reset();
        mode = 2'd2;
        reset = 1'b1;
        repeat (3) tick(1, 100);
        tests++;
        if ({bus.wr_en, triggered, capture_done, state_o} !== 5'b0 || bus.wr_addr !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got wr_en %b trig %b done %b state %0d addr %0d, required all 0",
                     bus.wr_en, triggered, capture_done, state_o, bus.wr_addr);
        end
        reset = 1'b0;
        repeat (3) tick(0, 0);
        tests++;
        if (state_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_single_idle: state %0d, required 0", state_o);
        end
        mode = 2'd0;
        repeat (2) tick(0, 0);
        tests++;
        if (state_o !== 2'd1) begin
            fails++;
            $display("FAIL reset_auto_armed: state %0d, required 1", state_o);
        end
    endtask

    task automatic test_ramp();
        int cd0;
        decim = 0;
        do_reset(2'd1);
        cd0 = cd_cnt;
        stream(700, 0);
        tests++;
        if (q.size() != 0 || cd_cnt - cd0 != 1 || state_o !== 2'd3 || triggered !== 1'b0) begin
            fails++;
            $display("FAIL ramp_done: pending %0d done_pulses %0d state %0d trig %b, required 0 1 3 0",
                     q.size(), cd_cnt - cd0, state_o, triggered);
        end
        frame_done = 1'b1;
        tick(0, 0);
        frame_done = 1'b0;
        tick(0, 0);
        tests++;
        if (state_o !== 2'd1) begin
            fails++;
            $display("FAIL ramp_rearm: state %0d, required 1", state_o);
        end
    endtask

    task automatic test_decim();
        decim = 3;
        do_reset(2'd1);
        stream(2100, 0);
        tests++;
        if (q.size() != 0 || state_o !== 2'd3) begin
            fails++;
            $display("FAIL decim_done: pending %0d state %0d, required 0 3", q.size(), state_o);
        end
        decim = 0;
    endtask

    task automatic test_normal_no_trig();
        int w0;
        do_reset(2'd1);
        w0 = wr_cnt;
        stream(10000, 1);
        tests++;
        if (wr_cnt != w0 || state_o !== 2'd1) begin
            fails++;
            $display("FAIL normal_no_trig: writes %0d state %0d, required 0 1", wr_cnt - w0, state_o);
        end
    endtask

    task automatic test_auto();
        int w0;
        do_reset(2'd0);
        w0 = wr_cnt;
        stream(2540, 1);
        tests++;
        if (q.size() != 0 || wr_cnt - w0 != DEPTH || state_o !== 2'd3) begin
            fails++;
            $display("FAIL auto_timeout: pending %0d writes %0d state %0d, required 0 %0d 3",
                     q.size(), wr_cnt - w0, state_o, DEPTH);
        end
    endtask

    task automatic test_single();
        do_reset(2'd2);
        for (int k = 0; k < 300; k++) tick(1, (16 * k) % 4096);
        tests++;
        if (state_o !== 2'd0) begin
            fails++;
            $display("FAIL single_idle: state %0d, required 0", state_o);
        end
        arm = 1'b1;
        tick(0, 0);
        arm = 1'b0;
        tick(0, 0);
        tests++;
        if (state_o !== 2'd1) begin
            fails++;
            $display("FAIL single_arm: state %0d, required 1", state_o);
        end
        stream(700, 0);
        arm = 1'b1;
        tick(0, 0);
        arm = 1'b0;
        tick(0, 0);
        tests++;
        if (state_o !== 2'd3 || q.size() != 0) begin
            fails++;
            $display("FAIL single_hold_arm: state %0d pending %0d, required 3 0", state_o, q.size());
        end
        arm = 1'b1;
        frame_done = 1'b1;
        tick(0, 0);
        arm = 1'b0;
        frame_done = 1'b0;
        for (int k = 0; k < 400; k++) tick(1, (16 * k) % 4096);
        tests++;
        if (state_o !== 2'd0) begin
            fails++;
            $display("FAIL single_frame_idle: state %0d, required 0", state_o);
        end
    endtask

    task automatic test_falling();
        trig_slope = 1'b1;
        trig_level = 12'd1000;
        do_reset(2'd1);
        stream(600, 2);
        tests++;
        if (q.size() != 0 || state_o !== 2'd3) begin
            fails++;
            $display("FAIL falling_done: pending %0d state %0d, required 0 3", q.size(), state_o);
        end
        trig_slope = 1'b0;
        trig_level = 12'd2048;
    endtask

    task automatic test_reset_mid();
        int cd0;
        do_reset(2'd0);
        cd0 = cd_cnt;
        for (int k = 0; k < 329; k++) begin
            if (k >= 128) push(k - 128, (16 * k) % 4096);
            tick(1, (16 * k) % 4096);
        end
        tests++;
        if (triggered !== 1'b1) begin
            fails++;
            $display("FAIL mid_triggered: trig %b, required 1", triggered);
        end
        reset = 1'b1;
        tick(1, 4000);
        @(negedge clk);
        tests++;
        if (bus.wr_en !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_wr_en: wr_en %b, required 0", bus.wr_en);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick(0, 0);
        tests++;
        if (state_o !== 2'd1 || triggered !== 1'b0 || cd_cnt != cd0 || q.size() != 0) begin
            fails++;
            $display("FAIL mid_reset_after: state %0d trig %b done_pulses %0d pending %0d, required 1 0 0 0",
                     state_o, triggered, cd_cnt - cd0, q.size());
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample = '0;
        test_reset();
        test_ramp();
        test_decim();
        test_normal_no_trig();
        test_auto();
        test_single();
        test_falling();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
